// File: rtl/mc_control_fsm_pkg.sv
// Shared MIPS multi-cycle control definitions: opcode/funct values, FSM states,
// datapath mux encodings and the packed control word driven by the FSM.
package mc_control_fsm_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned BT_W    = 3;

    localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
    localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
    localparam logic [OP_W-1:0] OP_J      = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
    localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
    localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
    localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI   = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI   = 6'h0C;
    localparam logic [OP_W-1:0] OP_LUI    = 6'h0F;
    localparam logic [OP_W-1:0] OP_MUL    = 6'h1C;
    localparam logic [OP_W-1:0] OP_LW     = 6'h23;
    localparam logic [OP_W-1:0] OP_SW     = 6'h2B;

    localparam logic [FN_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FN_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FN_W-1:0] FN_SRA  = 6'h03;
    localparam logic [FN_W-1:0] FN_JR   = 6'h08;
    localparam logic [FN_W-1:0] FN_JALR = 6'h09;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EX_R, ST_WB_R, ST_EX_I, ST_WB_I,
        ST_EX_ADDR, ST_MEM_RD, ST_WB_MEM, ST_MEM_WR, ST_EX_BR, ST_EX_J, ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
    } op_class_e;

    // Low three ALUOp bits; bit 3 carries OpCode[0] (signed/unsigned, eq/ne)
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_BRCMP = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_MUL   = 3'b110;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_RS     = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_RS    = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_SHAMT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RT     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [SEL_W-1:0] DST_RT = 2'b00;
    localparam logic [SEL_W-1:0] DST_RD = 2'b01;
    localparam logic [SEL_W-1:0] DST_RA = 2'b10;

    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

    localparam logic [BT_W-1:0] BT_OTHER = 3'b000;
    localparam logic [BT_W-1:0] BT_BEQ   = 3'b001;
    localparam logic [BT_W-1:0] BT_BNE   = 3'b010;
    localparam logic [BT_W-1:0] BT_BLEZ  = 3'b011;
    localparam logic [BT_W-1:0] BT_BGTZ  = 3'b100;

    typedef struct packed {
        logic               mem_req;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               pc_write;
        logic               pc_write_cond;
        logic [SEL_W-1:0]   pc_source;
        logic               reg_write;
        logic [SEL_W-1:0]   reg_dst;
        logic [SEL_W-1:0]   mem_to_reg;
        logic [SEL_W-1:0]   alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic               ext_op;
        logic               lu_op;
        logic [ALUOP_W-1:0] alu_op;
        logic [BT_W-1:0]    branch_type;
        logic               instr_done;
        logic               illegal;
    } ctrl_t;

    function automatic logic [BT_W-1:0] branch_type_of(input logic [OP_W-1:0] op);
        case (op)
            OP_BEQ:  return BT_BEQ;
            OP_BNE:  return BT_BNE;
            OP_BLEZ: return BT_BLEZ;
            OP_BGTZ: return BT_BGTZ;
            default: return BT_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/mc_op_classify.sv
// Combinational instruction classifier feeding the DECODE next-state choice.
module mc_op_classify
    import mc_control_fsm_pkg::*;
(
    input  logic [OP_W-1:0] op_code,
    input  logic [FN_W-1:0] funct,
    output op_class_e       op_class_c
);

    always_comb begin
        op_class_c = CLS_ILLEGAL;
        case (op_code)
            OP_RTYPE: op_class_c = (funct == FN_JR || funct == FN_JALR) ? CLS_JUMP : CLS_R;
            OP_MUL:   op_class_c = CLS_R;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
                      op_class_c = CLS_IMM;
            OP_LW:    op_class_c = CLS_LOAD;
            OP_SW:    op_class_c = CLS_STORE;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                      op_class_c = CLS_BRANCH;
            OP_J, OP_JAL:
                      op_class_c = CLS_JUMP;
            default:  op_class_c = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects and memory handshake from the current state.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     OpCode,
    input  logic [FN_W-1:0]     Funct,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic [SEL_W-1:0]    PCSource,
    output logic                RegWrite,
    output logic [SEL_W-1:0]    RegDst,
    output logic [SEL_W-1:0]    MemtoReg,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic                ExtOp,
    output logic                LuOp,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [BT_W-1:0]     Branchtype,
    output logic                instr_done,
    output logic                illegal
);

    state_e    state_q, state_d;
    op_class_e op_class_c;
    ctrl_t     ctrl_c;
    logic      is_shift_c;

    mc_op_classify u_classify (
        .op_code    (OpCode),
        .funct      (Funct),
        .op_class_c (op_class_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op_class_c)
                    CLS_R:                state_d = ST_EX_R;
                    CLS_IMM:              state_d = ST_EX_I;
                    CLS_LOAD, CLS_STORE:  state_d = ST_EX_ADDR;
                    CLS_BRANCH:           state_d = ST_EX_BR;
                    CLS_JUMP:             state_d = ST_EX_J;
                    default:              state_d = ST_TRAP;
                endcase
            end
            ST_EX_R:    state_d = ST_WB_R;
            ST_EX_I:    state_d = ST_WB_I;
            ST_EX_ADDR: state_d = (op_class_c == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  if (mem_ready) state_d = ST_WB_MEM;
            ST_MEM_WR:  if (mem_ready) state_d = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_EX_BR, ST_EX_J:
                        state_d = ST_FETCH;
            ST_TRAP:    state_d = ST_TRAP;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign is_shift_c = (OpCode == OP_RTYPE) &&
                        (Funct == FN_SLL || Funct == FN_SRL || Funct == FN_SRA);

    // Only the strobes that complete a memory handshake look at mem_ready
    always_comb begin
        ctrl_c = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.iord      = 1'b0;
                ctrl_c.alu_src_a = SRCA_PC;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = {1'b0, ALU_ADD};
                ctrl_c.pc_source = PCSRC_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl_c.alu_src_a = SRCA_PC;
                ctrl_c.alu_src_b = SRCB_IMM_SH;
                ctrl_c.ext_op    = 1'b1;
                ctrl_c.alu_op    = {1'b0, ALU_ADD};
            end
            ST_EX_R: begin
                ctrl_c.alu_src_a = is_shift_c ? SRCA_SHAMT : SRCA_RS;
                ctrl_c.alu_src_b = SRCB_RT;
                ctrl_c.alu_op    = {OpCode[0], (OpCode == OP_MUL) ? ALU_MUL : ALU_FUNCT};
            end
            ST_EX_I: begin
                ctrl_c.alu_src_a = SRCA_RS;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.ext_op    = (OpCode != OP_ANDI);
                ctrl_c.lu_op     = (OpCode == OP_LUI);
                case (OpCode)
                    OP_SLTI, OP_SLTIU: ctrl_c.alu_op = {OpCode[0], ALU_SLT};
                    OP_ANDI:           ctrl_c.alu_op = {OpCode[0], ALU_AND};
                    default:           ctrl_c.alu_op = {OpCode[0], ALU_ADD};
                endcase
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = (state_q == ST_WB_R) ? DST_RD : DST_RT;
                ctrl_c.mem_to_reg = (state_q == ST_WB_MEM) ? M2R_MDR : M2R_ALUOUT;
                ctrl_c.instr_done = 1'b1;
            end
            ST_EX_ADDR: begin
                ctrl_c.alu_src_a = SRCA_RS;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.ext_op    = 1'b1;
                ctrl_c.alu_op    = {1'b0, ALU_ADD};
            end
            ST_MEM_RD: begin
                ctrl_c.mem_req  = 1'b1;
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_c.mem_req    = 1'b1;
                ctrl_c.mem_write  = 1'b1;
                ctrl_c.iord       = 1'b1;
                ctrl_c.instr_done = mem_ready;
            end
            ST_EX_BR: begin
                ctrl_c.alu_src_a     = SRCA_RS;
                ctrl_c.alu_src_b     = SRCB_RT;
                ctrl_c.alu_op        = {OpCode[0], ALU_BRCMP};
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCSRC_ALUOUT;
                ctrl_c.branch_type   = branch_type_of(OpCode);
                ctrl_c.instr_done    = 1'b1;
            end
            ST_EX_J: begin
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.pc_source  = (OpCode == OP_RTYPE) ? PCSRC_RS : PCSRC_JUMP;
                ctrl_c.instr_done = 1'b1;
                if (OpCode == OP_JAL) begin
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.reg_dst    = DST_RA;
                    ctrl_c.mem_to_reg = M2R_PC;
                end else if (OpCode == OP_RTYPE && Funct == FN_JALR) begin
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.reg_dst    = DST_RD;
                    ctrl_c.mem_to_reg = M2R_PC;
                end
            end
            ST_TRAP:  ctrl_c.illegal = 1'b1;
            default:  ctrl_c = '0;
        endcase
    end

    assign mem_req     = ctrl_c.mem_req;
    assign IorD        = ctrl_c.iord;
    assign MemRead     = ctrl_c.mem_read;
    assign MemWrite    = ctrl_c.mem_write;
    assign IRWrite     = ctrl_c.ir_write;
    assign PCWrite     = ctrl_c.pc_write;
    assign PCWriteCond = ctrl_c.pc_write_cond;
    assign PCSource    = ctrl_c.pc_source;
    assign RegWrite    = ctrl_c.reg_write;
    assign RegDst      = ctrl_c.reg_dst;
    assign MemtoReg    = ctrl_c.mem_to_reg;
    assign ALUSrcA     = ctrl_c.alu_src_a;
    assign ALUSrcB     = ctrl_c.alu_src_b;
    assign ExtOp       = ctrl_c.ext_op;
    assign LuOp        = ctrl_c.lu_op;
    assign ALUOp       = ctrl_c.alu_op;
    assign Branchtype  = ctrl_c.branch_type;
    assign instr_done  = ctrl_c.instr_done;
    assign illegal     = ctrl_c.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: stimulus pushes the per-cycle expected control
// word, a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [5:0]  OpCode, Funct;
    logic        mem_ready;
    logic        mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic [1:0]  PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
    logic        RegWrite, ExtOp, LuOp, instr_done, illegal;
    logic [3:0]  ALUOp;
    logic [2:0]  Branchtype;

    ctrl_t       act;
    ctrl_t       exp_q[$];
    string       tag_q[$];
    ctrl_t       mon_e;
    string       mon_t;
    logic [5:0]  cur_op, cur_fn;
    int          checks;
    int          errors;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .LuOp(LuOp), .ALUOp(ALUOp),
        .Branchtype(Branchtype), .instr_done(instr_done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        act               = '0;
        act.mem_req       = mem_req;
        act.iord          = IorD;
        act.mem_read      = MemRead;
        act.mem_write     = MemWrite;
        act.ir_write      = IRWrite;
        act.pc_write      = PCWrite;
        act.pc_write_cond = PCWriteCond;
        act.pc_source     = PCSource;
        act.reg_write     = RegWrite;
        act.reg_dst       = RegDst;
        act.mem_to_reg    = MemtoReg;
        act.alu_src_a     = ALUSrcA;
        act.alu_src_b     = ALUSrcB;
        act.ext_op        = ExtOp;
        act.lu_op         = LuOp;
        act.alu_op        = ALUOp;
        act.branch_type   = Branchtype;
        act.instr_done    = instr_done;
        act.illegal       = illegal;
    end

    // Monitor: every cycle the DUT presents a control word; compare against the queue head
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", mon_t, act, mon_e);
            end
        end
    end

    // Expected control words, built field by field from the state descriptions
    function automatic ctrl_t c_zero();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

    function automatic ctrl_t c_fetch(input logic rdy);
        ctrl_t c;
        c = '0;
        c.mem_req = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        c.ir_write = rdy; c.pc_write = rdy;
        return c;
    endfunction

    function automatic ctrl_t c_decode();
        ctrl_t c;
        c = '0;
        c.alu_src_b = 2'b11; c.ext_op = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_exr(input logic [1:0] a, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        c.alu_src_a = a; c.alu_src_b = 2'b00; c.alu_op = op;
        return c;
    endfunction

    function automatic ctrl_t c_exi(input logic ext, input logic lu, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = ext; c.lu_op = lu; c.alu_op = op;
        return c;
    endfunction

    function automatic ctrl_t c_wb(input logic [1:0] dst, input logic [1:0] m2r);
        ctrl_t c;
        c = '0;
        c.reg_write = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_exaddr();
        ctrl_t c;
        c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_mem(input logic rd, input logic rdy);
        ctrl_t c;
        c = '0;
        c.mem_req = 1'b1; c.iord = 1'b1; c.mem_read = rd; c.mem_write = !rd;
        c.instr_done = !rd && rdy;
        return c;
    endfunction

    function automatic ctrl_t c_exbr(input logic [2:0] bt, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        c.alu_src_a = 2'b01; c.alu_op = op; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.branch_type = bt; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_exj(input logic [1:0] pcs, input logic rw,
                                    input logic [1:0] dst, input logic [1:0] m2r);
        ctrl_t c;
        c = '0;
        c.pc_write = 1'b1; c.pc_source = pcs; c.reg_write = rw;
        c.reg_dst = dst; c.mem_to_reg = m2r; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_trap();
        ctrl_t c;
        c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    // One clock: drive inputs just after the edge and queue the word expected this cycle
    task automatic cyc(input ctrl_t e, input string tag,
                       input logic rdy = 1'b1, input logic rst = 1'b1);
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_ready = rdy;
        OpCode    = cur_op;
        Funct     = cur_fn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        cur_op = op;
        cur_fn = fn;
    endtask

    task automatic run_branch(input logic [5:0] op, input logic [2:0] bt,
                              input logic [3:0] aop, input string tag);
        set_instr(op, 6'h00);
        cyc(c_fetch(1'b1), {tag, "_fetch"});
        cyc(c_decode(), {tag, "_decode"});
        cyc(c_exbr(bt, aop), {tag, "_ex"});
    endtask

    task automatic run_imm(input logic [5:0] op, input logic ext, input logic lu,
                           input logic [3:0] aop, input string tag);
        set_instr(op, 6'h00);
        cyc(c_fetch(1'b1), {tag, "_fetch"});
        cyc(c_decode(), {tag, "_decode"});
        cyc(c_exi(ext, lu, aop), {tag, "_ex"});
        cyc(c_wb(2'b00, 2'b00), {tag, "_wb"});
    endtask

    task automatic run_jump(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] pcs,
                            input logic rw, input logic [1:0] dst, input logic [1:0] m2r,
                            input string tag);
        set_instr(op, fn);
        cyc(c_fetch(1'b1), {tag, "_fetch"});
        cyc(c_decode(), {tag, "_decode"});
        cyc(c_exj(pcs, rw, dst, m2r), {tag, "_ex"});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        OpCode    = 6'h00;
        Funct     = 6'h00;
        set_instr(6'h00, 6'h00);

        cyc(c_zero(), "reset0", 1'b0, 1'b0);
        cyc(c_zero(), "reset1", 1'b1, 1'b0);
        cyc(c_zero(), "idle", 1'b1, 1'b1);

        // add: 4 cycles, writeback to rd
        set_instr(6'h00, 6'h20);
        cyc(c_fetch(1'b1), "add_fetch");
        cyc(c_decode(), "add_decode");
        cyc(c_exr(2'b01, 4'b0010), "add_ex");
        cyc(c_wb(2'b01, 2'b00), "add_wb");

        // sll uses shamt; mem_ready in DECODE must be ignored
        set_instr(6'h00, 6'h00);
        cyc(c_fetch(1'b1), "sll_fetch");
        cyc(c_decode(), "sll_decode", 1'b1);
        cyc(c_exr(2'b10, 4'b0010), "sll_ex", 1'b0);
        cyc(c_wb(2'b01, 2'b00), "sll_wb");

        // mul (0x1C, funct 02) is not a shift
        set_instr(6'h1C, 6'h02);
        cyc(c_fetch(1'b1), "mul_fetch");
        cyc(c_decode(), "mul_decode");
        cyc(c_exr(2'b01, 4'b0110), "mul_ex");
        cyc(c_wb(2'b01, 2'b00), "mul_wb");

        // lw with two wait cycles in MEM_RD: 7 cycles total
        set_instr(6'h23, 6'h00);
        cyc(c_fetch(1'b1), "lw_fetch");
        cyc(c_decode(), "lw_decode");
        cyc(c_exaddr(), "lw_addr");
        cyc(c_mem(1'b1, 1'b0), "lw_wait0", 1'b0);
        cyc(c_mem(1'b1, 1'b0), "lw_wait1", 1'b0);
        cyc(c_mem(1'b1, 1'b1), "lw_mem", 1'b1);
        cyc(c_wb(2'b00, 2'b01), "lw_wb");

        // sw with one fetch wait cycle
        set_instr(6'h2B, 6'h00);
        cyc(c_fetch(1'b0), "sw_fetch_wait", 1'b0);
        cyc(c_fetch(1'b1), "sw_fetch");
        cyc(c_decode(), "sw_decode");
        cyc(c_exaddr(), "sw_addr", 1'b1);
        cyc(c_mem(1'b0, 1'b1), "sw_mem", 1'b1);

        run_branch(6'h04, 3'b001, 4'b0001, "beq");
        run_branch(6'h05, 3'b010, 4'b1001, "bne");
        run_branch(6'h06, 3'b011, 4'b0001, "blez");
        run_branch(6'h07, 3'b100, 4'b1001, "bgtz");
        run_branch(6'h01, 3'b000, 4'b1001, "regimm");

        run_imm(6'h08, 1'b1, 1'b0, 4'b0000, "addi");
        run_imm(6'h0C, 1'b0, 1'b0, 4'b0100, "andi");
        run_imm(6'h0B, 1'b1, 1'b0, 4'b1101, "sltiu");
        run_imm(6'h0F, 1'b1, 1'b1, 4'b1000, "lui");

        run_jump(6'h02, 6'h00, 2'b10, 1'b0, 2'b00, 2'b00, "j");
        run_jump(6'h03, 6'h00, 2'b10, 1'b1, 2'b10, 2'b10, "jal");
        run_jump(6'h00, 6'h08, 2'b11, 1'b0, 2'b00, 2'b00, "jr");
        run_jump(6'h00, 6'h09, 2'b11, 1'b1, 2'b01, 2'b10, "jalr");

        // Reset while a store waits: request drops in the same cycle
        set_instr(6'h2B, 6'h00);
        cyc(c_fetch(1'b1), "swr_fetch");
        cyc(c_decode(), "swr_decode");
        cyc(c_exaddr(), "swr_addr", 1'b0);
        cyc(c_mem(1'b0, 1'b0), "swr_wait", 1'b0);
        cyc(c_zero(), "swr_rst", 1'b1, 1'b0);
        cyc(c_zero(), "swr_rst_hold", 1'b1, 1'b0);
        cyc(c_zero(), "swr_idle", 1'b1, 1'b1);

        // Unsupported opcode traps and stays there
        set_instr(6'h3F, 6'h00);
        cyc(c_fetch(1'b1), "ill_fetch");
        cyc(c_decode(), "ill_decode");
        cyc(c_trap(), "trap0", 1'b1);
        cyc(c_trap(), "trap1", 1'b0);
        cyc(c_trap(), "trap2", 1'b1);
        cyc(c_zero(), "trap_rst", 1'b1, 1'b0);
        cyc(c_zero(), "trap_idle", 1'b0, 1'b1);
        cyc(c_fetch(1'b0), "post_trap_fetch", 1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
